// File: rtl/bp_be_pkg.sv
// Shared definitions for the BE issue queue: pointer struct generator and assertion messages.
// The queue's optional same-cycle bypass is enabled by defining BP_BE_ISSUE_QUEUE_BYPASS_EN.

// Expands to a packed pointer typedef: wrap bit above a ring index of idx_w bits.
`define BP_BE_IQ_PTR_S(name, idx_w) \
  typedef struct packed { \
    logic              wrap; \
    logic [(idx_w)-1:0] idx; \
  } name

package bp_be_pkg;

  localparam int bp_be_iq_default_entries_gp = 8;

  localparam string bp_be_iq_yumi_msg_gp = "bp_be_issue_queue: iss_yumi_i asserted while iss_v_o is low";
  localparam string bp_be_iq_cmt_msg_gp  = "bp_be_issue_queue: cmt_v_i asserted with no issued packet outstanding";

  `BP_BE_IQ_PTR_S(bp_be_iq_ptr_s, $clog2(bp_be_iq_default_entries_gp));

endpackage

// File: rtl/bp_be_iq_ptr.sv
// Wrap-bit ring pointer: synchronous active-low reset, load beats increment.
// Counts modulo 2^width_p, i.e. modulo twice the queue depth when the MSB is the wrap bit.

module bp_be_iq_ptr #(
  parameter int width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               inc_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  output logic [width_p-1:0] ptr_o
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      ptr_o <= '0;
    end else if (load_i) begin
      ptr_o <= load_val_i;
    end else if (inc_i) begin
      ptr_o <= ptr_o + width_p'(1);
    end
  end

endmodule

// File: rtl/bp_be_issue_queue.sv
// Rollback-capable issue buffer between the FE queue and BE dispatch: write, issue and commit pointers.
// Define BP_BE_ISSUE_QUEUE_BYPASS_EN to forward an enqueue straight to the issue port when the queue has nothing unissued.

module bp_be_issue_queue
  import bp_be_pkg::*;
#(
  parameter int entries_p           = 8,
  parameter int pkt_width_p         = 128,
  parameter int almost_full_slack_p = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,

  input  logic                         enq_v_i,
  input  logic [pkt_width_p-1:0]       enq_pkt_i,
  output logic                         enq_ready_o,

  output logic                         iss_v_o,
  output logic [pkt_width_p-1:0]       iss_pkt_o,
  input  logic                         iss_yumi_i,

  input  logic                         cmt_v_i,
  input  logic                         roll_v_i,
  input  logic                         clr_v_i,

  output logic [$clog2(entries_p):0]   count_o,
  output logic                         almost_full_o,
  output logic                         empty_o
);

  localparam int idx_w_lp = $clog2(entries_p);
  localparam int ptr_w_lp = idx_w_lp + 1;

  `BP_BE_IQ_PTR_S(iq_ptr_s, idx_w_lp);

  iq_ptr_s wptr, iptr, cptr, cptr_n;

  logic [ptr_w_lp-1:0]    occupancy;
  logic                   full;
  logic                   unissued;
  logic                   enq_fire;
  logic                   iss_fire;
  logic                   cmt_fire;
  logic                   bypass;
  logic                   rewind;

  logic [pkt_width_p-1:0] ram [entries_p];

  // Status derived purely from registered pointers; the wrap bit separates full from empty.
  assign occupancy = wptr - cptr;
  assign full      = (occupancy == ptr_w_lp'(entries_p));
  assign unissued  = (iptr != wptr);

  // Ready does not look ahead at a same-cycle commit, so a full queue stalls for that cycle.
  assign enq_ready_o = reset_n_i & ~full & ~clr_v_i;
  assign enq_fire    = enq_v_i & enq_ready_o;

`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
  assign bypass = ~unissued & enq_fire & ~roll_v_i;
`else
  assign bypass = 1'b0;
`endif

  assign iss_v_o   = (reset_n_i & unissued & ~roll_v_i & ~clr_v_i) | bypass;
  assign iss_pkt_o = bypass ? enq_pkt_i : ram[iptr.idx];
  assign iss_fire  = iss_yumi_i & iss_v_o;

  // An illegal commit with nothing issued is dropped rather than corrupting the invariant.
  assign cmt_fire = cmt_v_i & (cptr != iptr);
  assign cptr_n   = cptr + {{(ptr_w_lp-1){1'b0}}, cmt_fire};

  // Roll and clear both return the issue pointer to the post-commit position.
  assign rewind = roll_v_i | clr_v_i;

  bp_be_iq_ptr #(.width_p(ptr_w_lp)) wptr_reg (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .inc_i      (enq_fire),
    .load_i     (clr_v_i),
    .load_val_i (cptr_n),
    .ptr_o      (wptr)
  );

  bp_be_iq_ptr #(.width_p(ptr_w_lp)) iptr_reg (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .inc_i      (iss_fire),
    .load_i     (rewind),
    .load_val_i (cptr_n),
    .ptr_o      (iptr)
  );

  bp_be_iq_ptr #(.width_p(ptr_w_lp)) cptr_reg (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .inc_i      (cmt_fire),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (cptr)
  );

  // NOTE: the packet RAM is deliberately not reset; pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (enq_fire) begin
      ram[wptr.idx] <= enq_pkt_i;
    end
  end

  assign count_o       = reset_n_i ? occupancy : '0;
  assign almost_full_o = reset_n_i
                       & ((ptr_w_lp'(entries_p) - occupancy) <= ptr_w_lp'(almost_full_slack_p));
  assign empty_o       = (count_o == '0);

  yumi_legal_a : assert property (@(posedge clk_i) disable iff (!reset_n_i) iss_yumi_i |-> iss_v_o)
    else $error("%s", bp_be_iq_yumi_msg_gp);

  cmt_legal_a : assert property (@(posedge clk_i) disable iff (!reset_n_i) cmt_v_i |-> (cptr != iptr))
    else $error("%s", bp_be_iq_cmt_msg_gp);

endmodule
